// File: rtl/barrett_stream_scheduler_pkg.sv
// Shared types and constants for the Barrett stream scheduler and its result FIFO.
// Default modulus constants describe the Dilithium prime.
package barrett_stream_scheduler_pkg;

    localparam int DATA_LENGTH    = 32;
    localparam int MODULUS        = 8380417;
    localparam int MODULUS_LENGTH = 23;
    localparam int MU             = 8396807;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } barrett_sched_state_e;

endpackage

// File: rtl/barrett_stream_scheduler_result_fifo.sv
// Synchronous result FIFO. Push and pop in one cycle are both honoured, even when full.
// The head reads as zero while the FIFO is empty, so an idle output bus stays quiet.
module barrett_result_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wp;
    logic [AW:0]      r_rp;
    logic             w_push;
    logic             w_pop;

    assign o_count = r_wp - r_rp;
    assign o_empty = (r_wp == r_rp);
    assign o_full  = (o_count == (AW+1)'(DEPTH));
    assign w_pop   = i_pop & ~o_empty;
    assign w_push  = i_push & (~o_full | w_pop);
    assign o_data  = o_empty ? '0 : r_mem[r_rp[AW-1:0]];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wp <= '0;
            r_rp <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + 1'b1;
            if (w_pop)  r_rp <= r_rp + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wp[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/barrett_stream_scheduler.sv
// Feeds one non-stallable barrett_pipelined core from a valid/ready operand stream,
// reserving FIFO space per issue (credits) and reprogramming the modulus only once drained.
module barrett_stream_scheduler
    import barrett_stream_scheduler_pkg::*;
#(
    parameter int PIPE_LATENCY = 4,
    parameter int FIFO_DEPTH   = 8,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                   CLK_pci_sys_clk_p,
    input  logic                   rst_i,
    input  logic                   cfg_valid_i,
    output logic                   cfg_ready_o,
    input  logic [DATA_LENGTH-1:0] cfg_q_i,
    input  logic [DATA_LENGTH-1:0] cfg_q_bl_i,
    input  logic [DATA_LENGTH-1:0] cfg_mu_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [DATA_LENGTH-1:0] in_data_i,
    output logic                   core_start_o,
    output logic [DATA_LENGTH-1:0] core_x_o,
    output logic [DATA_LENGTH-1:0] core_q_o,
    output logic [DATA_LENGTH-1:0] core_q_bl_o,
    output logic [DATA_LENGTH-1:0] core_mu_o,
    input  logic [DATA_LENGTH-1:0] core_result_i,
    input  logic                   core_valid_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [DATA_LENGTH-1:0] out_data_o,
    output logic [CNT_WIDTH-1:0]   result_cnt_o,
    output logic                   err_o,
    output barrett_sched_state_e   dbg_state_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int IW = $clog2(FIFO_DEPTH + 1);
    localparam int BW = $clog2(PIPE_LATENCY + 2);

    barrett_sched_state_e    r_state;
    logic [IW-1:0]           r_inflight;
    logic [PIPE_LATENCY-1:0] r_exp_sr;
    logic [BW-1:0]           r_blank_cnt;
    logic                    r_start;
    logic [DATA_LENGTH-1:0]  r_x;
    logic [DATA_LENGTH-1:0]  r_q;
    logic [DATA_LENGTH-1:0]  r_q_bl;
    logic [DATA_LENGTH-1:0]  r_mu;
    logic [CNT_WIDTH-1:0]    r_result_cnt;
    logic                    r_err;

    logic                    w_blank_done;
    logic                    w_core_valid;
    logic                    w_exp_valid;
    logic                    w_in_fire;
    logic                    w_cfg_fire;
    logic                    w_dec;
    logic                    w_fifo_push;
    logic                    w_fifo_pop;
    logic                    w_full;
    logic                    w_empty;
    logic [AW:0]             w_count;
    logic [IW:0]             w_occupancy;
    logic                    w_mismatch;
    logic                    w_overflow;
    logic                    w_orphan;

    // Core output is ignored until the pre-reset pipeline contents have flushed out.
    assign w_blank_done = (r_blank_cnt == BW'(PIPE_LATENCY + 1));
    assign w_core_valid = core_valid_i & w_blank_done;
    assign w_exp_valid  = r_exp_sr[PIPE_LATENCY-1];

    assign w_fifo_pop   = ~w_empty & out_ready_i;
    assign w_fifo_push  = w_core_valid & (~w_full | w_fifo_pop);
    assign w_occupancy  = (IW+1)'(r_inflight) + (IW+1)'(w_count);

    assign in_ready_o   = ~rst_i & (r_state == S_RUN) & ~cfg_valid_i &
                          (w_occupancy < (IW+1)'(FIFO_DEPTH));
    assign cfg_ready_o  = ~rst_i & ((r_state == S_IDLE) |
                          ((r_state == S_DRAIN) & (r_inflight == '0)));
    assign w_in_fire    = in_valid_i & in_ready_o;
    assign w_cfg_fire   = cfg_valid_i & cfg_ready_o;
    assign w_dec        = w_core_valid & (r_inflight != '0);

    assign w_mismatch   = w_blank_done & (core_valid_i != w_exp_valid);
    assign w_overflow   = w_core_valid & w_full & ~w_fifo_pop;
    assign w_orphan     = w_core_valid & (r_inflight == '0);

    assign core_start_o = r_start;
    assign core_x_o     = r_x;
    assign core_q_o     = r_q;
    assign core_q_bl_o  = r_q_bl;
    assign core_mu_o    = r_mu;
    assign out_valid_o  = ~w_empty;
    assign result_cnt_o = r_result_cnt;
    assign err_o        = r_err;
    assign dbg_state_o  = r_state;

    barrett_result_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_LENGTH)
    ) u_fifo (
        .i_clk   (CLK_pci_sys_clk_p),
        .i_rst   (rst_i),
        .i_push  (w_fifo_push),
        .i_data  (core_result_i),
        .i_pop   (w_fifo_pop),
        .o_data  (out_data_o),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge CLK_pci_sys_clk_p) begin
        if (rst_i) begin
            r_state      <= S_IDLE;
            r_inflight   <= '0;
            r_exp_sr     <= '0;
            r_blank_cnt  <= '0;
            r_start      <= 1'b0;
            r_x          <= '0;
            r_q          <= '0;
            r_q_bl       <= '0;
            r_mu         <= '0;
            r_result_cnt <= '0;
            r_err        <= 1'b0;
        end else begin
            r_start  <= w_in_fire;
            if (w_in_fire) r_x <= in_data_i;
            r_exp_sr <= {r_exp_sr[PIPE_LATENCY-2:0], r_start};
            if (!w_blank_done) r_blank_cnt <= r_blank_cnt + 1'b1;

            if (w_in_fire && !w_dec)      r_inflight <= r_inflight + 1'b1;
            else if (w_dec && !w_in_fire) r_inflight <= r_inflight - 1'b1;

            if (w_fifo_pop) r_result_cnt <= r_result_cnt + 1'b1;
            r_err <= r_err | w_mismatch | w_overflow | w_orphan;

            if (w_cfg_fire) begin
                r_q    <= cfg_q_i;
                r_q_bl <= cfg_q_bl_i;
                r_mu   <= cfg_mu_i;
            end

            case (r_state)
                S_IDLE:  if (w_cfg_fire)  r_state <= S_RUN;
                S_RUN:   if (cfg_valid_i) r_state <= S_DRAIN;
                S_DRAIN: if (w_cfg_fire)  r_state <= S_RUN;
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
